// File: rtl/pipe_hazard_unit.sv
// Hazard detection and operand forwarding for the IF/ID/RR/EX/MA/WB pipeline.
// Tracks EX/MA/WB destination tags and drives stall, bubble, freeze and flush.
module pipe_hazard_unit #(
    parameter int DATA_W      = 16,
    parameter int REG_AW      = 3,
    parameter int ZERO_REG_EN = 0,
    parameter int CNT_W       = 16
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              rr_valid_i,
    input  logic [REG_AW-1:0] rr_sa_i,
    input  logic [REG_AW-1:0] rr_sb_i,
    input  logic              rr_use_a_i,
    input  logic              rr_use_b_i,
    input  logic [REG_AW-1:0] rr_dest_i,
    input  logic              rr_wr_en_i,
    input  logic              rr_is_load_i,
    input  logic [DATA_W-1:0] rf_a_data_i,
    input  logic [DATA_W-1:0] rf_b_data_i,
    input  logic [DATA_W-1:0] ex_result_i,
    input  logic [DATA_W-1:0] ma_result_i,
    input  logic [DATA_W-1:0] wb_result_i,
    input  logic              ex_wr_kill_i,
    input  logic              ex_busy_i,
    input  logic              branch_taken_i,
    output logic [DATA_W-1:0] fwd_a_data_o,
    output logic [DATA_W-1:0] fwd_b_data_o,
    output logic [1:0]        fwd_a_sel_o,
    output logic [1:0]        fwd_b_sel_o,
    output logic              stall_o,
    output logic              bubble_o,
    output logic              freeze_o,
    output logic              flush_o,
    output logic [CNT_W-1:0]  stall_cnt_o,
    output logic [CNT_W-1:0]  flush_cnt_o
);

    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] dest;
        logic              wr_en;
        logic              is_load;
    } tag_t;

    localparam logic ZERO_HW = (ZERO_REG_EN != 0);

    localparam logic [1:0] SEL_RF = 2'd0;
    localparam logic [1:0] SEL_EX = 2'd1;
    localparam logic [1:0] SEL_MA = 2'd2;
    localparam logic [1:0] SEL_WB = 2'd3;

    tag_t ex_tag_q, ex_tag_d;
    tag_t ma_tag_q, ma_tag_d;
    tag_t wb_tag_q, wb_tag_d;

    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    logic live_a, live_b;
    logic ex_hit_a, ex_hit_b;
    logic ma_hit_a, ma_hit_b;
    logic wb_hit_a, wb_hit_b;
    logic ex_fwd_a, ex_fwd_b;
    logic load_use;
    logic stall, flush, freeze;
    logic [1:0] sel_a, sel_b;

    function automatic logic src_live(input logic [REG_AW-1:0] s, input logic use_bit);
        return use_bit && !(ZERO_HW && (s == '0));
    endfunction

    function automatic logic tag_hit(input tag_t t, input logic [REG_AW-1:0] s);
        return t.valid && t.wr_en && (t.dest == s);
    endfunction

    function automatic logic [1:0] pick_src(input logic ex_fwd, input logic ma_hit,
                                            input logic wb_hit);
        if (ex_fwd)      return SEL_EX;
        else if (ma_hit) return SEL_MA;
        else if (wb_hit) return SEL_WB;
        else             return SEL_RF;
    endfunction

    function automatic logic [DATA_W-1:0] fwd_mux(input logic [1:0] sel,
                                                  input logic [DATA_W-1:0] rf,
                                                  input logic [DATA_W-1:0] ex,
                                                  input logic [DATA_W-1:0] ma,
                                                  input logic [DATA_W-1:0] wb);
        case (sel)
            SEL_EX:  return ex;
            SEL_MA:  return ma;
            SEL_WB:  return wb;
            default: return rf;
        endcase
    endfunction

    // A load match in EX never forwards; the operand falls through to older stages
    // and the instruction is held for one cycle until the load reaches MA.
    always_comb begin
        live_a   = src_live(rr_sa_i, rr_use_a_i);
        live_b   = src_live(rr_sb_i, rr_use_b_i);
        ex_hit_a = live_a && tag_hit(ex_tag_q, rr_sa_i) && !ex_wr_kill_i;
        ex_hit_b = live_b && tag_hit(ex_tag_q, rr_sb_i) && !ex_wr_kill_i;
        ma_hit_a = live_a && tag_hit(ma_tag_q, rr_sa_i);
        ma_hit_b = live_b && tag_hit(ma_tag_q, rr_sb_i);
        wb_hit_a = live_a && tag_hit(wb_tag_q, rr_sa_i);
        wb_hit_b = live_b && tag_hit(wb_tag_q, rr_sb_i);
        ex_fwd_a = ex_hit_a && !ex_tag_q.is_load;
        ex_fwd_b = ex_hit_b && !ex_tag_q.is_load;

        sel_a = pick_src(ex_fwd_a, ma_hit_a, wb_hit_a);
        sel_b = pick_src(ex_fwd_b, ma_hit_b, wb_hit_b);

        load_use = rr_valid_i && ex_tag_q.is_load &&
                   ((ex_hit_a && !ex_fwd_a) || (ex_hit_b && !ex_fwd_b));

        // Reset gating keeps flush/freeze quiet while the tag pipe is being cleared.
        freeze = rst_ni && ex_busy_i;
        flush  = rst_ni && branch_taken_i && !ex_busy_i;
        stall  = load_use && !ex_busy_i && !branch_taken_i;
    end

    always_comb begin
        ex_tag_d = ex_tag_q;
        ma_tag_d = ma_tag_q;
        wb_tag_d = wb_tag_q;
        if (!freeze) begin
            wb_tag_d       = ma_tag_q;
            ma_tag_d       = ex_tag_q;
            ma_tag_d.wr_en = ex_tag_q.wr_en && !ex_wr_kill_i;
            if (rr_valid_i && !stall && !flush) begin
                ex_tag_d.valid   = 1'b1;
                ex_tag_d.dest    = rr_dest_i;
                ex_tag_d.wr_en   = rr_wr_en_i;
                ex_tag_d.is_load = rr_is_load_i;
            end else begin
                ex_tag_d.valid = 1'b0;
            end
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
        if (flush && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ex_tag_q    <= '0;
            ma_tag_q    <= '0;
            wb_tag_q    <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            ex_tag_q    <= ex_tag_d;
            ma_tag_q    <= ma_tag_d;
            wb_tag_q    <= wb_tag_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign fwd_a_sel_o  = sel_a;
    assign fwd_b_sel_o  = sel_b;
    assign fwd_a_data_o = fwd_mux(sel_a, rf_a_data_i, ex_result_i, ma_result_i, wb_result_i);
    assign fwd_b_data_o = fwd_mux(sel_b, rf_b_data_i, ex_result_i, ma_result_i, wb_result_i);
    assign stall_o      = stall;
    assign bubble_o     = stall;
    assign freeze_o     = freeze;
    assign flush_o      = flush;
    assign stall_cnt_o  = stall_cnt_q;
    assign flush_cnt_o  = flush_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_unit.sv
// Bench for pipe_hazard_unit: vector table, directed corner sequences and a
// randomized run against an in-flight-instruction reference model.
module tb_pipe_hazard_unit;
    localparam int DW = 16;
    localparam int AW = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    logic rr_valid, rr_use_a, rr_use_b, rr_wr_en, rr_is_load;
    logic [AW-1:0] rr_sa, rr_sb, rr_dest;
    logic [DW-1:0] rf_a, rf_b, ex_res, ma_res, wb_res;
    logic ex_wr_kill, ex_busy, branch_taken;

    logic [DW-1:0] fa0, fb0, fa1, fb1;
    logic [1:0]    sa0, sb0, sa1, sb1;
    logic          st0, bu0, fz0, fl0, st1, bu1, fz1, fl1;
    logic [15:0]   sc0, fc0;
    logic [3:0]    sc1, fc1;

    pipe_hazard_unit #(.DATA_W(16), .REG_AW(3), .ZERO_REG_EN(0), .CNT_W(16)) u0 (
        .clk_i(clk), .rst_ni(rst_n), .rr_valid_i(rr_valid), .rr_sa_i(rr_sa), .rr_sb_i(rr_sb),
        .rr_use_a_i(rr_use_a), .rr_use_b_i(rr_use_b), .rr_dest_i(rr_dest), .rr_wr_en_i(rr_wr_en),
        .rr_is_load_i(rr_is_load), .rf_a_data_i(rf_a), .rf_b_data_i(rf_b), .ex_result_i(ex_res),
        .ma_result_i(ma_res), .wb_result_i(wb_res), .ex_wr_kill_i(ex_wr_kill), .ex_busy_i(ex_busy),
        .branch_taken_i(branch_taken), .fwd_a_data_o(fa0), .fwd_b_data_o(fb0), .fwd_a_sel_o(sa0),
        .fwd_b_sel_o(sb0), .stall_o(st0), .bubble_o(bu0), .freeze_o(fz0), .flush_o(fl0),
        .stall_cnt_o(sc0), .flush_cnt_o(fc0));

    pipe_hazard_unit #(.DATA_W(16), .REG_AW(3), .ZERO_REG_EN(1), .CNT_W(4)) u1 (
        .clk_i(clk), .rst_ni(rst_n), .rr_valid_i(rr_valid), .rr_sa_i(rr_sa), .rr_sb_i(rr_sb),
        .rr_use_a_i(rr_use_a), .rr_use_b_i(rr_use_b), .rr_dest_i(rr_dest), .rr_wr_en_i(rr_wr_en),
        .rr_is_load_i(rr_is_load), .rf_a_data_i(rf_a), .rf_b_data_i(rf_b), .ex_result_i(ex_res),
        .ma_result_i(ma_res), .wb_result_i(wb_res), .ex_wr_kill_i(ex_wr_kill), .ex_busy_i(ex_busy),
        .branch_taken_i(branch_taken), .fwd_a_data_o(fa1), .fwd_b_data_o(fb1), .fwd_a_sel_o(sa1),
        .fwd_b_sel_o(sb1), .stall_o(st1), .bubble_o(bu1), .freeze_o(fz1), .flush_o(fl1),
        .stall_cnt_o(sc1), .flush_cnt_o(fc1));

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // ---------------- reference model: list of in-flight instructions ----------------
    typedef struct {
        bit v;
        int d;
        bit w;
        bit l;
    } ent_t;

    ent_t fl[2][3];   // [dut][0=EX,1=MA,2=WB]
    int   msc[2];
    int   mfc[2];

    function automatic void m_reset();
        for (int d = 0; d < 2; d++) begin
            for (int k = 0; k < 3; k++) fl[d][k] = '{v: 0, d: 0, w: 0, l: 0};
            msc[d] = 0;
            mfc[d] = 0;
        end
    endfunction

    function automatic void m_src(input int d, input int s, input bit u, input logic [15:0] rf,
                                  output int sel, output logic [15:0] dat, output bit lu);
        sel = 0;
        dat = rf;
        lu  = 0;
        if (!u || (d == 1 && s == 0)) return;
        for (int k = 0; k < 3; k++) begin
            if (fl[d][k].v && fl[d][k].w && fl[d][k].d == s && !(k == 0 && ex_wr_kill)) begin
                if (k == 0 && fl[d][k].l) lu = 1;
                else begin
                    sel = k + 1;
                    dat = (k == 0) ? ex_res : (k == 1) ? ma_res : wb_res;
                    return;
                end
            end
        end
    endfunction

    function automatic void m_eval(input int d, output int sa, output logic [15:0] da,
                                   output int sb, output logic [15:0] db,
                                   output bit st, output bit fz, output bit fla);
        bit lua, lub;
        m_src(d, int'(rr_sa), rr_use_a, rf_a, sa, da, lua);
        m_src(d, int'(rr_sb), rr_use_b, rf_b, sb, db, lub);
        st  = rst_n && rr_valid && (lua || lub) && !ex_busy && !branch_taken;
        fz  = rst_n && ex_busy;
        fla = rst_n && branch_taken && !ex_busy;
    endfunction

    function automatic void m_adv(input int d);
        int sa, sb, mx;
        logic [15:0] da, db;
        bit st, fz, fla;
        m_eval(d, sa, da, sb, db, st, fz, fla);
        mx = (d == 0) ? 65535 : 15;
        if (st && msc[d] < mx) msc[d]++;
        if (fla && mfc[d] < mx) mfc[d]++;
        if (!ex_busy) begin
            fl[d][2]   = fl[d][1];
            fl[d][1]   = fl[d][0];
            fl[d][1].w = fl[d][1].w && !ex_wr_kill;
            if (rr_valid && !st && !fla)
                fl[d][0] = '{v: 1, d: int'(rr_dest), w: rr_wr_en, l: rr_is_load};
            else
                fl[d][0] = '{v: 0, d: 0, w: 0, l: 0};
        end
    endfunction

    task automatic check_model(input int d);
        int sa, sb;
        logic [15:0] da, db;
        bit st, fz, fla;
        string p;
        p = (d == 0) ? "rnd u0" : "rnd u1";
        m_eval(d, sa, da, sb, db, st, fz, fla);
        chk({p, " sel_a"},  d ? sa1 : sa0, sa);
        chk({p, " sel_b"},  d ? sb1 : sb0, sb);
        chk({p, " data_a"}, d ? fa1 : fa0, da);
        chk({p, " data_b"}, d ? fb1 : fb0, db);
        chk({p, " stall"},  d ? st1 : st0, st);
        chk({p, " bubble"}, d ? bu1 : bu0, st);
        chk({p, " freeze"}, d ? fz1 : fz0, fz);
        chk({p, " flush"},  d ? fl1 : fl0, fla);
        chk({p, " stall_cnt"}, d ? {12'h0, sc1} : {16'h0, sc0}, msc[d]);
        chk({p, " flush_cnt"}, d ? {12'h0, fc1} : {16'h0, fc0}, mfc[d]);
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic set_idle();
        rr_valid = 0; rr_use_a = 0; rr_use_b = 0; rr_wr_en = 0; rr_is_load = 0;
        rr_sa = '0; rr_sb = '0; rr_dest = '0;
        ex_wr_kill = 0; ex_busy = 0; branch_taken = 0;
        rf_a = 16'hAAAA; rf_b = 16'hBBBB;
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_cycles(input int n);
        set_idle();
        repeat (n) tick();
    endtask

    task automatic issue(input logic [2:0] dest, input logic ld);
        set_idle();
        rr_valid = 1; rr_dest = dest; rr_wr_en = 1; rr_is_load = ld;
    endtask

    task automatic consume(input logic [2:0] sa, input logic [2:0] sb, input logic ua,
                           input logic ub, input logic [2:0] dest);
        set_idle();
        rr_valid = 1; rr_sa = sa; rr_sb = sb; rr_use_a = ua; rr_use_b = ub;
        rr_dest = dest; rr_wr_en = 1;
    endtask

    typedef struct {
        logic [2:0]  p_dest;
        logic        p_ld;
        logic [2:0]  c_sa;
        logic [2:0]  c_sb;
        logic        ua;
        logic        ub;
        logic [15:0] ex;
        logic [1:0]  e_sa;
        logic [15:0] e_da;
        logic [1:0]  e_sb;
        logic [15:0] e_db;
        logic        e_st;
    } vec_t;

    vec_t tbl[7];

    initial begin
        tbl[0] = '{3'd1, 1'b0, 3'd1, 3'd3, 1'b1, 1'b1, 16'h0042, 2'd1, 16'h0042, 2'd0, 16'hBBBB, 1'b0};
        tbl[1] = '{3'd5, 1'b0, 3'd2, 3'd5, 1'b1, 1'b1, 16'h00F0, 2'd0, 16'hAAAA, 2'd1, 16'h00F0, 1'b0};
        tbl[2] = '{3'd7, 1'b0, 3'd7, 3'd7, 1'b1, 1'b1, 16'h7777, 2'd1, 16'h7777, 2'd1, 16'h7777, 1'b0};
        tbl[3] = '{3'd0, 1'b0, 3'd0, 3'd0, 1'b1, 1'b1, 16'h0101, 2'd1, 16'h0101, 2'd1, 16'h0101, 1'b0};
        tbl[4] = '{3'd4, 1'b0, 3'd3, 3'd2, 1'b1, 1'b1, 16'h1234, 2'd0, 16'hAAAA, 2'd0, 16'hBBBB, 1'b0};
        tbl[5] = '{3'd1, 1'b0, 3'd1, 3'd1, 1'b0, 1'b1, 16'h5555, 2'd0, 16'hAAAA, 2'd1, 16'h5555, 1'b0};
        tbl[6] = '{3'd6, 1'b1, 3'd1, 3'd2, 1'b1, 1'b1, 16'h6666, 2'd0, 16'hAAAA, 2'd0, 16'hBBBB, 1'b0};

        ex_res = 16'h0; ma_res = 16'h0; wb_res = 16'h0;
        set_idle();
        rst_n = 0;
        branch_taken = 1; ex_busy = 1;
        #1;
        chk("reset flush", fl0, 0);
        chk("reset freeze", fz0, 0);
        chk("reset stall", st0, 0);
        chk("reset sel_a", sa0, 0);
        chk("reset data_a", fa0, 16'hAAAA);
        chk("reset data_b", fb0, 16'hBBBB);
        chk("reset stall_cnt", sc0, 0);
        chk("reset flush_cnt", fc0, 0);
        set_idle();
        @(negedge clk);
        rst_n = 1;
        idle_cycles(2);

        // Single-producer forwarding vectors
        for (int i = 0; i < 7; i++) begin
            idle_cycles(3);
            issue(tbl[i].p_dest, tbl[i].p_ld);
            tick();
            consume(tbl[i].c_sa, tbl[i].c_sb, tbl[i].ua, tbl[i].ub, 3'd2);
            ex_res = tbl[i].ex;
            #1;
            chk($sformatf("vec%0d sel_a", i), sa0, tbl[i].e_sa);
            chk($sformatf("vec%0d data_a", i), fa0, tbl[i].e_da);
            chk($sformatf("vec%0d sel_b", i), sb0, tbl[i].e_sb);
            chk($sformatf("vec%0d data_b", i), fb0, tbl[i].e_db);
            chk($sformatf("vec%0d stall", i), st0, tbl[i].e_st);
            tick();
        end
        idle_cycles(3);

        // Load-use: one stall cycle then MA forwarding
        issue(3'd1, 1'b1);
        tick();
        consume(3'd1, 3'd1, 1, 1, 3'd2);
        ma_res = 16'h1234;
        #1;
        chk("lu stall", st0, 1);
        chk("lu bubble", bu0, 1);
        tick();
        consume(3'd1, 3'd1, 1, 1, 3'd2);
        #1;
        chk("lu stall_cnt", sc0, 1);
        chk("lu post stall", st0, 0);
        chk("lu sel_a", sa0, 2);
        chk("lu sel_b", sb0, 2);
        chk("lu data_a", fa0, 16'h1234);
        chk("lu data_b", fb0, 16'h1234);
        tick();
        idle_cycles(3);

        // MA beats WB; zero register
        issue(3'd1, 0); tick();
        issue(3'd1, 0); tick();
        issue(3'd3, 0); tick();
        consume(3'd1, 3'd4, 1, 0, 3'd5);
        ma_res = 16'h0005; wb_res = 16'h0009;
        #1;
        chk("ma>wb sel_a", sa0, 2);
        chk("ma>wb data_a", fa0, 16'h0005);
        tick();
        idle_cycles(3);
        issue(3'd0, 0); tick();
        consume(3'd0, 3'd0, 1, 0, 3'd5);
        ex_res = 16'hE0E0;
        #1;
        chk("r0 u1 sel_a", sa1, 0);
        chk("r0 u1 data_a", fa1, 16'hAAAA);
        chk("r0 u0 sel_a", sa0, 1);
        tick();
        idle_cycles(3);

        // Branch coincident with load-use
        issue(3'd2, 1); tick();
        consume(3'd2, 3'd0, 1, 0, 3'd4);
        branch_taken = 1;
        #1;
        chk("br flush", fl0, 1);
        chk("br stall", st0, 0);
        chk("br bubble", bu0, 0);
        tick();
        consume(3'd4, 3'd0, 1, 0, 3'd6);
        #1;
        chk("br ex invalid sel_a", sa0, 0);
        chk("br flush_cnt", fc0, 1);
        chk("br stall_cnt", sc0, 1);
        tick();
        idle_cycles(3);

        // Freeze for three cycles; branch ignored while busy
        issue(3'd3, 0); tick();
        for (int i = 0; i < 3; i++) begin
            consume(3'd3, 3'd0, 1, 0, 3'd5);
            ex_busy = 1; branch_taken = 1; ex_res = 16'h0ABC;
            #1;
            chk($sformatf("frz%0d freeze", i), fz0, 1);
            chk($sformatf("frz%0d flush", i), fl0, 0);
            chk($sformatf("frz%0d stall", i), st0, 0);
            chk($sformatf("frz%0d sel_a", i), sa0, 1);
            tick();
        end
        consume(3'd3, 3'd0, 1, 0, 3'd5);
        ex_res = 16'h0ABC;
        #1;
        chk("frz rel freeze", fz0, 0);
        chk("frz rel sel_a", sa0, 1);
        chk("frz rel data_a", fa0, 16'h0ABC);
        chk("frz flush_cnt", fc0, 1);
        tick();
        idle_cycles(3);

        // Reset asserted during a stall
        issue(3'd1, 1); tick();
        consume(3'd1, 3'd0, 1, 0, 3'd2);
        #1;
        chk("rst pre stall", st0, 1);
        rst_n = 0;
        #1;
        chk("rst stall", st0, 0);
        chk("rst bubble", bu0, 0);
        chk("rst sel_a", sa0, 0);
        chk("rst data_a", fa0, 16'hAAAA);
        chk("rst stall_cnt", sc0, 0);
        chk("rst flush_cnt", fc0, 0);
        chk("rst u1 stall_cnt", sc1, 0);
        #1;
        rst_n = 1;
        idle_cycles(3);

        // Counter saturation on the 4-bit instance
        for (int i = 0; i < 20; i++) begin
            issue(3'd1, 1); tick();
            consume(3'd1, 3'd0, 1, 0, 3'd2); tick();
            consume(3'd1, 3'd0, 1, 0, 3'd2); tick();
        end
        #1;
        chk("sat u1 stall_cnt", sc1, 15);
        chk("sat u0 stall_cnt", sc0, 20);
        issue(3'd1, 1); tick();
        consume(3'd1, 3'd0, 1, 0, 3'd2);
        #1;
        chk("sat extra stall", st1, 1);
        tick();
        #1;
        chk("sat u1 held", sc1, 15);
        chk("sat u0 more", sc0, 21);
        idle_cycles(3);

        // Randomized run against the model
        rst_n = 0;
        #1;
        m_reset();
        #1;
        rst_n = 1;
        @(negedge clk);
        for (int n = 0; n < 3000; n++) begin
            rst_n        = ($urandom_range(0, 149) != 0);
            rr_valid     = ($urandom_range(0, 99) < 85);
            rr_sa        = 3'($urandom_range(0, 7));
            rr_sb        = 3'($urandom_range(0, 7));
            rr_dest      = 3'($urandom_range(0, 7));
            rr_use_a     = 1'($urandom_range(0, 1));
            rr_use_b     = 1'($urandom_range(0, 1));
            rr_wr_en     = ($urandom_range(0, 3) != 0);
            rr_is_load   = ($urandom_range(0, 9) < 3);
            ex_wr_kill   = ($urandom_range(0, 9) == 0);
            ex_busy      = ($urandom_range(0, 9) == 0);
            branch_taken = ($urandom_range(0, 9) == 0);
            rf_a   = 16'($urandom);
            rf_b   = 16'($urandom);
            ex_res = 16'($urandom);
            ma_res = 16'($urandom);
            wb_res = 16'($urandom);
            #1;
            if (!rst_n) m_reset();
            check_model(0);
            check_model(1);
            @(posedge clk);
            if (rst_n) begin
                m_adv(0);
                m_adv(1);
            end
            @(negedge clk);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
